fmult_accum_seq: RTL and testbench

- Parametrised sequencer for the ADPCM pole/zero predictor.
- Steps through NZ zero taps (b_k × dq_k) and NP pole taps (a_k × sr_k) and issues one operand pair per cycle to an external FMULT instance through mul_a/mul_b.
- Accumulates the returned mul_w products internally and produces sez (zero-section estimate) and se (full estimate).
- Sits between the adaptive-predictor coefficient registers and the reconstruction path.
- Adds a start/busy/done handshake, configurable tap counts and multiplier latency, and a per-request pole-section bypass.

---
 rtl/fmult_accum_seq.sv | 185 ++++++++++++++++++
 tb/tb_fmult_accum_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmult_accum_seq.sv
// -----------------------------------------------------------------------------
// fmult_accum_seq
// Sequencer for the ADPCM pole/zero predictor. On a request it steps through
// NZ zero taps (b_k x dq_k) and, when enabled, NP pole taps (a_k x sr_k),
// presenting one operand pair per cycle to an external FMULT. The returned
// products are summed modulo 2^16. sez is taken after the last zero tap and
// se after the last enabled tap.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request; sampled only in IDLE or FIN
//   pole_en  sampled with start; 1 = include pole taps
//   b_flat   zero coefficients, tap k at [16k+15:16k]
//   dq_flat  quantised differences, tap k at [11k+10:11k]
//   a_flat   pole coefficients, tap k at [16k+15:16k]
//   sr_flat  reconstructed signals, tap k at [11k+10:11k]
//   mul_a    coefficient operand to FMULT (0 when no tap is issued)
//   mul_b    signal operand to FMULT (0 when no tap is issued)
//   mul_w    product from FMULT, MULT_LAT cycles after its operands
//   busy     request in progress
//   done     one-cycle pulse; sez/se valid
//   sez      acc[15:1] after the last zero tap
//   se       acc[15:1] after the last enabled tap
// -----------------------------------------------------------------------------
module fmult_accum_seq #(
  parameter int NZ       = 6,
  parameter int NP       = 2,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pole_en,
  input  logic [16*NZ-1:0]  b_flat,
  input  logic [11*NZ-1:0]  dq_flat,
  input  logic [16*NP-1:0]  a_flat,
  input  logic [11*NP-1:0]  sr_flat,
  output logic [15:0]       mul_a,
  output logic [10:0]       mul_b,
  input  logic [15:0]       mul_w,
  output logic              busy,
  output logic              done,
  output logic [14:0]       sez,
  output logic [14:0]       se
);

  // Wide enough for any tap index, tap count or drain count in one request.
  localparam int CW = $clog2(NZ + NP + MULT_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;      // index of the next tap to issue
  logic [CW-1:0]   n_taps_q;   // taps in the current request
  logic [15:0]     acc_q;
  logic [15:0]     acc_next;

  // Stage 0 travels with the operands; stage MULT_LAT lines up with mul_w.
  logic [MULT_LAT:0] v_pipe, lz_pipe, l_pipe;

  logic            accept, issue_more, drive, fin_now, add_now;
  logic [CW-1:0]   sel_idx, sel_n;
  logic [15:0]     tap_a;
  logic [10:0]     tap_b;
  logic            tap_lz, tap_l;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept     = start && (state_q == IDLE || state_q == FIN);
    issue_more = (state_q == ISSUE) && (cnt_q < n_taps_q);
    drive      = accept || issue_more;

    // On the accept edge the tap count is not registered yet, so derive it
    // directly from pole_en for tap 0's "last" flag.
    sel_idx = accept ? '0 : cnt_q;
    sel_n   = accept ? (pole_en ? CW'(NZ + NP) : CW'(NZ)) : n_taps_q;

    tap_a = '0;
    tap_b = '0;
    for (int k = 0; k < NZ; k++) begin
      if (sel_idx == CW'(k)) begin
        tap_a = b_flat[16*k +: 16];
        tap_b = dq_flat[11*k +: 11];
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (sel_idx == CW'(NZ + k)) begin
        tap_a = a_flat[16*k +: 16];
        tap_b = sr_flat[11*k +: 11];
      end
    end
    tap_lz = (sel_idx == CW'(NZ - 1));
    tap_l  = (sel_idx == sel_n - CW'(1));

    add_now  = v_pipe[MULT_LAT];
    fin_now  = v_pipe[MULT_LAT] && l_pipe[MULT_LAT];
    acc_next = acc_q + mul_w;   // modulo 2^16, no saturation
  end

  // Next-state logic. With MULT_LAT=0 the last product lands on the same edge
  // that would leave ISSUE, so FIN wins and DRAIN is never visited.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FIN: state_d = accept ? ISSUE : IDLE;
      ISSUE: begin
        if (fin_now)          state_d = FIN;
        else if (!issue_more) state_d = DRAIN;
      end
      DRAIN:     if (fin_now) state_d = FIN;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned only with non-blocking (<=) so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_taps_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fin_now;
      if (accept) begin
        n_taps_q <= sel_n;
        cnt_q    <= CW'(1);
        busy     <= 1'b1;
      end else begin
        if (issue_more) cnt_q <= cnt_q + CW'(1);
        if (fin_now)    busy  <= 1'b0;
      end
    end
  end

  // Operand register plus the flag pipeline that follows each tap to FMULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      v_pipe  <= '0;
      lz_pipe <= '0;
      l_pipe  <= '0;
    end else begin
      if (drive) begin
        mul_a      <= tap_a;
        mul_b      <= tap_b;
        v_pipe[0]  <= 1'b1;
        lz_pipe[0] <= tap_lz;
        l_pipe[0]  <= tap_l;
      end else begin
        mul_a      <= '0;
        mul_b      <= '0;
        v_pipe[0]  <= 1'b0;
        lz_pipe[0] <= 1'b0;
        l_pipe[0]  <= 1'b0;
      end
      for (int j = 1; j <= MULT_LAT; j++) begin
        v_pipe[j]  <= v_pipe[j-1];
        lz_pipe[j] <= lz_pipe[j-1];
        l_pipe[j]  <= l_pipe[j-1];
      end
    end
  end

  // Accumulator and result registers. sez/se keep their last values across
  // accepts and are only rewritten by the load edges of the next request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      sez   <= '0;
      se    <= '0;
    end else begin
      if (accept)       acc_q <= '0;
      else if (add_now) acc_q <= acc_next;
      if (add_now && lz_pipe[MULT_LAT]) sez <= acc_next[15:1];
      if (fin_now)                      se  <= acc_next[15:1];
    end
  end

endmodule

// File: tb/tb_fmult_accum_seq.sv
// -----------------------------------------------------------------------------
// Testbench for fmult_accum_seq. Two instances share operands: index 1 uses
// MULT_LAT=1 with a registered stub multiplier, index 0 uses MULT_LAT=0 with a
// combinational stub. The stub returns either a constant or a + b (16-bit), so
// the expected results are plain sums over the tap values.
// -----------------------------------------------------------------------------
module tb_fmult_accum_seq;

  localparam int NZ = 6;
  localparam int NP = 2;

  typedef struct {
    logic [14:0] sez;
    logic [14:0] se;
    int          acc_cyc;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start_v [2];
  logic              pole_en;
  logic [16*NZ-1:0]  b_flat;
  logic [11*NZ-1:0]  dq_flat;
  logic [16*NP-1:0]  a_flat;
  logic [11*NP-1:0]  sr_flat;
  logic [15:0]       mul_a_v [2];
  logic [10:0]       mul_b_v [2];
  logic              busy_v  [2];
  logic              done_v  [2];
  logic [14:0]       sez_v   [2];
  logic [14:0]       se_v    [2];
  logic [15:0]       mul_w1, mul_w0;

  logic        mode_rand;
  logic [15:0] cval;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int oi [2];
  int on [2];
  exp_t q1[$];
  exp_t q0[$];

  function automatic logic [15:0] stub(input logic [15:0] a, input logic [10:0] b,
                                       input logic mr, input logic [15:0] cv);
    return mr ? (a + {5'b0, b}) : cv;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) mul_w1 <= '0;
    else        mul_w1 <= stub(mul_a_v[1], mul_b_v[1], mode_rand, cval);
  end
  assign mul_w0 = stub(mul_a_v[0], mul_b_v[0], mode_rand, cval);

  fmult_accum_seq #(.NZ(NZ), .NP(NP), .MULT_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .pole_en(pole_en),
    .b_flat(b_flat), .dq_flat(dq_flat), .a_flat(a_flat), .sr_flat(sr_flat),
    .mul_a(mul_a_v[1]), .mul_b(mul_b_v[1]), .mul_w(mul_w1),
    .busy(busy_v[1]), .done(done_v[1]), .sez(sez_v[1]), .se(se_v[1])
  );

  fmult_accum_seq #(.NZ(NZ), .NP(NP), .MULT_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .pole_en(pole_en),
    .b_flat(b_flat), .dq_flat(dq_flat), .a_flat(a_flat), .sr_flat(sr_flat),
    .mul_a(mul_a_v[0]), .mul_b(mul_b_v[0]), .mul_w(mul_w0),
    .busy(busy_v[0]), .done(done_v[0]), .sez(sez_v[0]), .se(se_v[0])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_a(input int i);
    return (i < NZ) ? b_flat[16*i +: 16] : a_flat[16*(i-NZ) +: 16];
  endfunction

  function automatic logic [10:0] exp_b(input int i);
    return (i < NZ) ? dq_flat[11*i +: 11] : sr_flat[11*(i-NZ) +: 11];
  endfunction

  // Reference: sum of all products mod 2^16, halved into 15 bits.
  function automatic exp_t model(input logic pole, input int lat);
    exp_t        m;
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < NZ; k++) s = s + stub(exp_a(k), exp_b(k), mode_rand, cval);
    m.sez = s[15:1];
    if (pole)
      for (int k = 0; k < NP; k++) s = s + stub(exp_a(NZ+k), exp_b(NZ+k), mode_rand, cval);
    m.se      = s[15:1];
    m.n       = NZ + (pole ? NP : 0) + lat;
    m.acc_cyc = 0;
    return m;
  endfunction

  always @(posedge clk) cycle++;

  // Monitor: operand sequence, completion scoreboard, then accept detection
  // (start seen with busy low means the following edge accepts).
  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (oi[d] >= 0 && oi[d] < on[d]) begin
          check($sformatf("mul_a_dut%0d_tap%0d", d, oi[d]), 32'(mul_a_v[d]), 32'(exp_a(oi[d])));
          check($sformatf("mul_b_dut%0d_tap%0d", d, oi[d]), 32'(mul_b_v[d]), 32'(exp_b(oi[d])));
          oi[d]++;
        end else begin
          check($sformatf("idle_operands_dut%0d", d), {5'b0, mul_a_v[d], mul_b_v[d]}, 32'd0);
          oi[d] = -1;
        end

        if (done_v[d]) begin
          if ((d == 1 ? q1.size() : q0.size()) == 0) begin
            check($sformatf("unexpected_done_dut%0d", d), 32'(done_v[d]), 32'd0);
          end else begin
            if (d == 1) e = q1.pop_front();
            else        e = q0.pop_front();
            check($sformatf("sez_dut%0d", d), 32'(sez_v[d]), 32'(e.sez));
            check($sformatf("se_dut%0d", d), 32'(se_v[d]), 32'(e.se));
            check($sformatf("latency_dut%0d", d), 32'(cycle - e.acc_cyc), 32'(e.n));
            check($sformatf("busy_at_done_dut%0d", d), 32'(busy_v[d]), 32'd0);
          end
        end

        if (start_v[d] && !busy_v[d]) begin
          e = model(pole_en, (d == 1) ? 1 : 0);
          e.acc_cyc = cycle + 1;
          if (d == 1) q1.push_back(e);
          else        q0.push_back(e);
          oi[d] = 0;
          on[d] = NZ + (pole_en ? NP : 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_flats();
    for (int k = 0; k < NZ; k++) begin
      b_flat[16*k +: 16]  = 16'($urandom);
      dq_flat[11*k +: 11] = 11'($urandom);
    end
    for (int k = 0; k < NP; k++) begin
      a_flat[16*k +: 16]  = 16'($urandom);
      sr_flat[11*k +: 11] = 11'($urandom);
    end
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    while ((busy_v[d] || done_v[d]) && t < 60) begin
      tick();
      t++;
    end
    check($sformatf("idle_reached_dut%0d", d), 32'(busy_v[d] | done_v[d]), 32'd0);
    tick();
  endtask

  // One request, optionally followed by start pulses that land while busy.
  task automatic run_req(input int d, input logic pole, input int pulses);
    pole_en    = pole;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    for (int p = 0; p < pulses; p++) begin
      repeat ($urandom_range(1, 2)) tick();
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
    end
    wait_idle(d);
  endtask

  task automatic back_to_back(input int d, input int cycles);
    pole_en    = 1'b1;
    start_v[d] = 1'b1;
    repeat (cycles) tick();
    start_v[d] = 1'b0;
    wait_idle(d);
  endtask

  task automatic check_zero_outputs(input int d, input string tag);
    check($sformatf("%s_busy_dut%0d", tag, d), 32'(busy_v[d]), 32'd0);
    check($sformatf("%s_done_dut%0d", tag, d), 32'(done_v[d]), 32'd0);
    check($sformatf("%s_mul_a_dut%0d", tag, d), 32'(mul_a_v[d]), 32'd0);
    check($sformatf("%s_mul_b_dut%0d", tag, d), 32'(mul_b_v[d]), 32'd0);
    check($sformatf("%s_sez_dut%0d", tag, d), 32'(sez_v[d]), 32'd0);
    check($sformatf("%s_se_dut%0d", tag, d), 32'(se_v[d]), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    pole_en    = 1'b0;
    mode_rand  = 1'b0;
    cval       = 16'h0010;
    oi[0] = -1; oi[1] = -1;
    on[0] = 0;  on[1] = 0;
    randomize_flats();

    #2 reset = 1'b0;
    #1;
    check_zero_outputs(1, "por");
    check_zero_outputs(0, "por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Directed constant-product cases on the MULT_LAT=1 instance.
    cval = 16'h0010; run_req(1, 1'b1, 2);
    cval = 16'h7000; run_req(1, 1'b1, 0);
    cval = 16'hFFF0; run_req(1, 1'b1, 1);
    cval = 16'h0010; run_req(1, 1'b0, 1);

    // Randomised operands, products depend on every tap value.
    mode_rand = 1'b1;
    for (int r = 0; r < 16; r++) begin
      randomize_flats();
      run_req(1, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // start held high: each FIN edge accepts the next request.
    mode_rand = 1'b0; cval = 16'h0010;
    back_to_back(1, 30);
    mode_rand = 1'b1; randomize_flats();
    back_to_back(1, 25);

    // Combinational-multiplier build.
    mode_rand = 1'b0; cval = 16'h0010;
    run_req(0, 1'b1, 0);
    run_req(0, 1'b0, 1);
    mode_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      randomize_flats();
      run_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    back_to_back(0, 25);

    // Reset while tap 3 is on the operand bus.
    mode_rand = 1'b0; cval = 16'h0010;
    pole_en    = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    repeat (3) tick();
    check("tap3_before_reset", 32'(mul_a_v[1]), 32'(b_flat[16*3 +: 16]));
    #2 reset = 1'b0;
    #1;
    check_zero_outputs(1, "midreset");
    q1.delete();
    q0.delete();
    oi[0] = -1; oi[1] = -1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) tick();   // any done here has no queue entry and is flagged
    run_req(1, 1'b1, 0);

    check("pending_dut1", 32'(q1.size()), 32'd0);
    check("pending_dut0", 32'(q0.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
